// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Sequential read-after-write hazard detector for the ID stage of the in-order
// RV32I pipeline. Each architectural register carries a countdown of the
// cycles left until its pending result can be forwarded. The ID instruction
// stalls while any of its sources is still counting down. Branch and jalr
// resolve in ID, so they wait one cycle longer than EX consumers.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   id_valid_i          ID stage holds a real instruction
//   rs1_addr_ID_i/..    source addresses and their use flags
//   Branch_ID_i         conditional branch (resolved in ID)
//   Jalr_ID_i           jalr (resolved in ID)
//   rd_addr_ID_i        destination of the ID instruction
//   RegWrite_ID_i       ID instruction writes rd
//   MemRead_ID_i        ID instruction is a load
//   flush_id_i          ID instruction is killed this cycle
//   freeze_i            whole pipeline held; state does not advance
//   stall_o             hold IF/ID and bubble ID/EX (combinational)
//   pending_o           bit r set while register r has a result in flight
//   stall_cnt_o         saturating count of unfrozen stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int LOAD_LAT = 1,
    parameter int ALU_LAT  = 0,
    parameter int STAT_W   = 16,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    input  logic [AW-1:0]     rs1_addr_ID_i,
    input  logic              rs1_used_i,
    input  logic [AW-1:0]     rs2_addr_ID_i,
    input  logic              rs2_used_i,
    input  logic              Branch_ID_i,
    input  logic              Jalr_ID_i,
    input  logic [AW-1:0]     rd_addr_ID_i,
    input  logic              RegWrite_ID_i,
    input  logic              MemRead_ID_i,
    input  logic              flush_id_i,
    input  logic              freeze_i,
    output logic              stall_o,
    output logic [NUM_REGS-1:0] pending_o,
    output logic [STAT_W-1:0] stall_cnt_o
);

    localparam int MAX_LAT = (LOAD_LAT > ALU_LAT) ? LOAD_LAT : ALU_LAT;
    localparam int CW      = $clog2(MAX_LAT + 2);

    localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT + 1);
    localparam logic [CW-1:0] ALU_INIT  = CW'(ALU_LAT + 1);

    // Countdown per register. Entry 0 is never loaded (issue excludes rd=0)
    // and only ever decrements from zero-guarded values, so it stays 0.
    logic [CW-1:0] cnt [NUM_REGS];

    logic          id_class;
    logic [CW-1:0] cnt_rs1, cnt_rs2;
    logic          need_rs1, need_rs2;
    logic          hazard_rs1, hazard_rs2;
    logic          issue;

    // An ID-resolved consumer needs the value one cycle earlier than an EX
    // consumer, so it waits for the counter to reach 0 instead of 1.
    assign id_class   = Branch_ID_i | Jalr_ID_i;
    assign cnt_rs1    = cnt[rs1_addr_ID_i];
    assign cnt_rs2    = cnt[rs2_addr_ID_i];
    assign need_rs1   = id_valid_i & rs1_used_i & (rs1_addr_ID_i != '0);
    assign need_rs2   = id_valid_i & rs2_used_i & (rs2_addr_ID_i != '0);
    assign hazard_rs1 = id_class ? (cnt_rs1 != '0) : (cnt_rs1 > CW'(1));
    assign hazard_rs2 = id_class ? (cnt_rs2 != '0) : (cnt_rs2 > CW'(1));

    // Freeze deliberately does not mask the stall: the held instruction must
    // keep reporting its hazard so nothing slips through when the hold ends.
    assign stall_o = ~flush_id_i & ((need_rs1 & hazard_rs1) | (need_rs2 & hazard_rs2));

    assign issue = id_valid_i & RegWrite_ID_i & (rd_addr_ID_i != '0)
                 & ~stall_o & ~flush_id_i & ~freeze_i;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every counter samples the pre-edge values regardless of statement order.
    // NOTE: the counter array is a small flop bank, not a RAM, and must read
    // as idle straight out of reset, so every entry is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else if (!freeze_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                // The youngest producer overrides any countdown in flight (WAW).
                if (issue && (rd_addr_ID_i == r[AW-1:0])) begin
                    cnt[r] <= MemRead_ID_i ? LOAD_INIT : ALU_INIT;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (stall_o && !freeze_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + STAT_W'(1);
        end
    end

    // NOTE: the output vector gets a default before the loop so no bit can
    // hold its old value and infer a latch.
    always_comb begin
        pending_o = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_o[r] = (cnt[r] != '0);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. Two instances share the ID inputs: the
// default build (LOAD_LAT=1, ALU_LAT=0) and a LOAD_LAT=3 build with a 2-bit
// stall counter to exercise saturation. Every scenario starts from reset, so
// the instance not under test is simply ignored. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int AW       = 5;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] rs1_addr;
    logic          rs1_used;
    logic [AW-1:0] rs2_addr;
    logic          rs2_used;
    logic          branch;
    logic          jalr;
    logic [AW-1:0] rd_addr;
    logic          reg_write;
    logic          mem_read;
    logic          flush_id;
    logic          freeze;

    logic                stall;
    logic [NUM_REGS-1:0] pending;
    logic [15:0]         stall_cnt;

    logic                stall3;
    logic [NUM_REGS-1:0] pending3;
    logic [1:0]          stall_cnt3;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid),
        .rs1_addr_ID_i (rs1_addr),
        .rs1_used_i    (rs1_used),
        .rs2_addr_ID_i (rs2_addr),
        .rs2_used_i    (rs2_used),
        .Branch_ID_i   (branch),
        .Jalr_ID_i     (jalr),
        .rd_addr_ID_i  (rd_addr),
        .RegWrite_ID_i (reg_write),
        .MemRead_ID_i  (mem_read),
        .flush_id_i    (flush_id),
        .freeze_i      (freeze),
        .stall_o       (stall),
        .pending_o     (pending),
        .stall_cnt_o   (stall_cnt)
    );

    hazard_scoreboard #(
        .LOAD_LAT (3),
        .STAT_W   (2)
    ) dut3 (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid),
        .rs1_addr_ID_i (rs1_addr),
        .rs1_used_i    (rs1_used),
        .rs2_addr_ID_i (rs2_addr),
        .rs2_used_i    (rs2_used),
        .Branch_ID_i   (branch),
        .Jalr_ID_i     (jalr),
        .rd_addr_ID_i  (rd_addr),
        .RegWrite_ID_i (reg_write),
        .MemRead_ID_i  (mem_read),
        .flush_id_i    (flush_id),
        .freeze_i      (freeze),
        .stall_o       (stall3),
        .pending_o     (pending3),
        .stall_cnt_o   (stall_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        id_valid  = 1'b0;
        rs1_addr  = '0;
        rs1_used  = 1'b0;
        rs2_addr  = '0;
        rs2_used  = 1'b0;
        branch    = 1'b0;
        jalr      = 1'b0;
        rd_addr   = '0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        flush_id  = 1'b0;
    endtask

    task automatic do_reset();
        set_nop();
        freeze = 1'b0;
        rst    = 1'b1;
        #2;
        rst    = 1'b0;
        step();
    endtask

    // Producer with no sources, so it always issues on the next edge.
    task automatic producer(input int rd, input bit load);
        set_nop();
        id_valid  = 1'b1;
        rd_addr   = rd[AW-1:0];
        reg_write = 1'b1;
        mem_read  = load;
        step();
        set_nop();
    endtask

    task automatic consumer(input int rs1, input bit u1, input int rs2, input bit u2,
                            input bit br, input bit jr);
        set_nop();
        id_valid = 1'b1;
        rs1_addr = rs1[AW-1:0];
        rs1_used = u1;
        rs2_addr = rs2[AW-1:0];
        rs2_used = u2;
        branch   = br;
        jalr     = jr;
    endtask

    // Counts consecutive stall cycles of the held consumer, bounded so a stuck
    // stall shows up as a wrong count instead of a hang.
    task automatic count_stalls(input bit sel3, output int n);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!(sel3 ? stall3 : stall)) break;
            n++;
            @(posedge clk);
            #1;
        end
        set_nop();
    endtask

    int n;

    initial begin
        set_nop();
        freeze = 1'b0;
        rst    = 1'b1;
        #3;
        check("reset_stall",     32'(stall),     32'd0);
        check("reset_pending",   pending,        32'h0);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b0;
        step();

        // lw x5; beq x5,x0 -> 2 stall cycles
        producer(5, 1'b1);
        check("lw_pending", pending, 32'h0000_0020);
        consumer(5, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        count_stalls(1'b0, n);
        check("load_branch_stalls", n, 2);
        check("load_branch_cnt", 32'(stall_cnt), 32'd2);

        // lw x5; add x6,x5,x1 -> 1 stall
        do_reset();
        producer(5, 1'b1);
        consumer(5, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        count_stalls(1'b0, n);
        check("load_ex_stalls", n, 1);

        // add x7; jalr x7 -> 1 stall
        do_reset();
        producer(7, 1'b0);
        consumer(7, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        count_stalls(1'b0, n);
        check("alu_jalr_stalls", n, 1);

        // add x7; sub x8,x7,x1 -> 0 stalls
        do_reset();
        producer(7, 1'b0);
        consumer(7, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        count_stalls(1'b0, n);
        check("alu_ex_stalls", n, 0);

        // lw x5; beq x0,x0 -> x0 never hazards
        do_reset();
        producer(5, 1'b1);
        consumer(0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        count_stalls(1'b0, n);
        check("x0_stalls", n, 0);

        // lw x5; consumer with rs2=x5 but rs2 unused -> 0 stalls
        do_reset();
        producer(5, 1'b1);
        consumer(1, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        count_stalls(1'b0, n);
        check("rs2_unused_stalls", n, 0);

        // LOAD_LAT=3: lw x9; beq x9 -> 4 stalls, 2-bit counter saturates at 3
        do_reset();
        producer(9, 1'b1);
        consumer(9, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        count_stalls(1'b1, n);
        check("lat3_branch_stalls", n, 4);
        check("lat3_cnt_saturate", 32'(stall_cnt3), 32'd3);

        // LOAD_LAT=3: lw x9; add x10,x9 -> 3 stalls
        do_reset();
        producer(9, 1'b1);
        consumer(9, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        count_stalls(1'b1, n);
        check("lat3_ex_stalls", n, 3);

        // WAW: lw x5; add x5; beq x5 -> 1 stall
        do_reset();
        producer(5, 1'b1);
        producer(5, 1'b0);
        consumer(5, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        count_stalls(1'b0, n);
        check("waw_stalls", n, 1);

        // Freeze for 3 cycles in the middle of a load->branch stall
        do_reset();
        producer(5, 1'b1);
        consumer(5, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check("frz_pre_stall", 32'(stall), 32'd1);
        step();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("frz_stall_held", 32'(stall), 32'd1);
            step();
        end
        check("frz_pending", pending, 32'h0000_0020);
        check("frz_stall_cnt", 32'(stall_cnt), 32'd1);
        freeze = 1'b0;
        count_stalls(1'b0, n);
        check("frz_rest_stalls", n, 1);
        check("frz_total_cnt", 32'(stall_cnt), 32'd2);

        // Flushed jalr x11, x5 while x5 pending -> no stall, no issue
        do_reset();
        producer(5, 1'b1);
        consumer(5, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        rd_addr   = 5'd11;
        reg_write = 1'b1;
        flush_id  = 1'b1;
        @(negedge clk);
        check("flush_stall", 32'(stall), 32'd0);
        step();
        check("flush_no_issue", pending, 32'h0000_0020);
        check("flush_stall_cnt", 32'(stall_cnt), 32'd0);
        set_nop();

        // Asynchronous reset in the middle of a load->branch stall
        do_reset();
        producer(5, 1'b1);
        consumer(5, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        step();
        @(negedge clk);
        check("arst_pre_stall", 32'(stall), 32'd1);
        check("arst_pre_pending", pending, 32'h0000_0020);
        check("arst_pre_cnt", 32'(stall_cnt), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_pending", pending, 32'h0);
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        #1;
        rst = 1'b0;
        set_nop();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
